// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter: grant and trmt are registered one edge after req.
// Each grant holds off further grants until tx_done or a TO_CYCLES timeout (sticky err) frees the line.
module uart_tx_arb #(
   parameter int unsigned TO_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   output logic [3:0]  gnt,
   output logic        busy,
   output logic        err,
   input  logic        err_clr,
   output logic        trmt,
   output logic [7:0]  tx_data,
   input  logic        tx_done
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam logic [19:0] TO_LAST = 20'(TO_CYCLES - 1);

   state_t      state, state_nxt;
   logic [1:0]  last, last_nxt;
   logic [1:0]  win;
   logic        win_vld;
   logic [19:0] to_cnt, to_cnt_nxt;
   logic [3:0]  gnt_nxt;
   logic        trmt_nxt;
   logic [7:0]  tx_data_nxt;
   logic        err_nxt;

   // Walk from lowest to highest priority so the requester nearest last+1 wins.
   always_comb begin
      win     = 2'd0;
      win_vld = 1'b0;
      for (int k = 4; k >= 1; k--) begin
         if (req[last + 2'(k)]) begin
            win     = last + 2'(k);
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      last_nxt    = last;
      to_cnt_nxt  = to_cnt;
      gnt_nxt     = 4'b0000;
      trmt_nxt    = 1'b0;
      tx_data_nxt = tx_data;
      err_nxt     = err;
      if (err_clr) begin
         err_nxt = 1'b0;
      end
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nxt   = LAUNCH;
               gnt_nxt     = 4'b0001 << win;
               trmt_nxt    = 1'b1;
               tx_data_nxt = req_data[{win, 3'b000} +: 8];
               last_nxt    = win;
            end
         end
         LAUNCH: begin
            to_cnt_nxt = 20'd0;
            state_nxt  = WAIT_DONE;
         end
         WAIT_DONE: begin
            to_cnt_nxt = to_cnt + 20'd1;
            // A completion on the deadline edge still counts as success.
            if (tx_done) begin
               state_nxt = IDLE;
            end else if (to_cnt_nxt == TO_LAST) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         last    <= 2'd3;
         to_cnt  <= 20'd0;
         gnt     <= 4'b0000;
         trmt    <= 1'b0;
         tx_data <= 8'h00;
         err     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         last    <= last_nxt;
         to_cnt  <= to_cnt_nxt;
         gnt     <= gnt_nxt;
         trmt    <= trmt_nxt;
         tx_data <= tx_data_nxt;
         err     <= err_nxt;
         busy    <= (state_nxt != IDLE);
      end
   end

endmodule
